// File: rtl/keypad_decimal_entry_if.sv
// Keypad entry bundle: column drive / row sense plus the decoded entry outputs.
// The master side is the keypad_decimal_entry block; the slave side is the keypad/consumer.
interface keypad_decimal_entry_if;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [14:0] value;
  logic [2:0]  digit_count;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [14:0] committed_value;
  logic        commit;

  modport master (
    output col, value, digit_count, key_valid, key_code, committed_value, commit,
    input  row
  );

  modport slave (
    input  col, value, digit_count, key_valid, key_code, committed_value, commit,
    output row
  );
endinterface

// File: rtl/keypad_decimal_entry.sv
// 4x4 matrix keypad scanner with scan-level debounce, producing a 4-digit decimal
// entry value (0..9999) with backspace, clear and an Enter-latched commit register.
module keypad_decimal_entry #(
  parameter int unsigned SCAN_DIV       = 10000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                   sysclk,
  input  logic                   rst_n,
  keypad_decimal_entry_if.master bus
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned MW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic {IDLE, HELD} state_t;

  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [15:0]   raw_q, raw_d, prev_q, prev_d, deb_q, deb_d;
  logic [MW-1:0] match_q, match_d;
  state_t        state_q, state_d;
  logic          kv_q, kv_d, commit_q, commit_d;
  logic [3:0]    code_q, code_d;
  logic [14:0]   value_q, value_d, committed_q, committed_d;
  logic [2:0]    cnt_q, cnt_d;

  logic          sample, end_scan, one_hot;
  logic [3:0]    key_idx, key_lut;
  logic [17:0]   shifted;

  // Column scan and debounce; raw_d already holds column 3 when end_scan fires
  always_comb begin
    sample    = (dwell_q == DW'(SCAN_DIV - 1));
    end_scan  = sample && (col_idx_q == 2'd3);
    dwell_d   = sample ? '0 : dwell_q + DW'(1);
    col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;
    raw_d     = raw_q;
    if (sample) begin
      for (int unsigned r = 0; r < 4; r++) begin
        raw_d[{r[1:0], col_idx_q}] = ~row_s2_q[r];
      end
    end
    prev_d  = prev_q;
    match_d = match_q;
    deb_d   = deb_q;
    if (end_scan) begin
      prev_d = raw_d;
      if (raw_d == prev_q) begin
        if ({1'b0, match_q} + (MW+1)'(1) >= (MW+1)'(DEBOUNCE_SCANS)) begin
          match_d = MW'(DEBOUNCE_SCANS);
          deb_d   = raw_d;
        end else begin
          match_d = match_q + MW'(1);
        end
      end else begin
        match_d = '0;
      end
    end
  end

  always_comb begin
    one_hot = (deb_q != '0) && ((deb_q & (deb_q - 16'd1)) == '0);
    key_idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (deb_q[i]) key_idx = i[3:0];
    end
    case (key_idx)
      4'd0:    key_lut = 4'h1;
      4'd1:    key_lut = 4'h2;
      4'd2:    key_lut = 4'h3;
      4'd3:    key_lut = 4'hA;
      4'd4:    key_lut = 4'h4;
      4'd5:    key_lut = 4'h5;
      4'd6:    key_lut = 4'h6;
      4'd7:    key_lut = 4'hB;
      4'd8:    key_lut = 4'h7;
      4'd9:    key_lut = 4'h8;
      4'd10:   key_lut = 4'h9;
      4'd11:   key_lut = 4'hC;
      4'd12:   key_lut = 4'h0;
      4'd13:   key_lut = 4'hF;
      4'd14:   key_lut = 4'hE;
      default: key_lut = 4'hD;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    kv_d        = 1'b0;
    commit_d    = 1'b0;
    code_d      = code_q;
    value_d     = value_q;
    cnt_d       = cnt_q;
    committed_d = committed_q;
    shifted     = 18'(value_q) * 18'd10 + {14'd0, key_lut};
    case (state_q)
      IDLE: begin
        if (deb_q != '0) begin
          state_d = HELD;
          if (one_hot) begin
            kv_d   = 1'b1;
            code_d = key_lut;
            if (key_lut <= 4'd9) begin
              if (cnt_q < 3'd4) begin
                value_d = shifted[14:0];
                cnt_d   = cnt_q + 3'd1;
              end
            end else begin
              case (key_lut)
                4'hF: begin
                  value_d = value_q / 15'd10;
                  if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
                end
                4'hC: begin
                  value_d = '0;
                  cnt_d   = '0;
                end
                4'hE: begin
                  committed_d = value_q;
                  commit_d    = 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
      end
      default: begin
        if (deb_q == '0) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q    <= '1;
      row_s2_q    <= '1;
      dwell_q     <= '0;
      col_idx_q   <= '0;
      raw_q       <= '0;
      prev_q      <= '0;
      deb_q       <= '0;
      match_q     <= '0;
      state_q     <= IDLE;
      kv_q        <= 1'b0;
      commit_q    <= 1'b0;
      code_q      <= '0;
      value_q     <= '0;
      cnt_q       <= '0;
      committed_q <= '0;
    end else begin
      row_s1_q    <= bus.row;
      row_s2_q    <= row_s1_q;
      dwell_q     <= dwell_d;
      col_idx_q   <= col_idx_d;
      raw_q       <= raw_d;
      prev_q      <= prev_d;
      deb_q       <= deb_d;
      match_q     <= match_d;
      state_q     <= state_d;
      kv_q        <= kv_d;
      commit_q    <= commit_d;
      code_q      <= code_d;
      value_q     <= value_d;
      cnt_q       <= cnt_d;
      committed_q <= committed_d;
    end
  end

  assign bus.col             = ~(4'b0001 << col_idx_q);
  assign bus.value           = value_q;
  assign bus.digit_count     = cnt_q;
  assign bus.key_valid       = kv_q;
  assign bus.key_code        = code_q;
  assign bus.committed_value = committed_q;
  assign bus.commit          = commit_q;

endmodule

// File: tb/tb_keypad_decimal_entry.sv
// Bench for keypad_decimal_entry: a keypad model drives rows from the column strobes,
// a reference model queues expected key events and a monitor checks each key_valid.
module tb_keypad_decimal_entry;
  localparam int SD   = 4;
  localparam int DS   = 2;
  localparam int SCAN = 4 * SD;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  logic [15:0] pressed = '0;

  keypad_decimal_entry_if bus ();

  keypad_decimal_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  // Physical keypad: a pressed key pulls its row low while its column is driven low
  always_comb begin
    bus.row = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!bus.col[c] && pressed[r*4+c]) bus.row[r] = 1'b0;
  end

  typedef struct {
    int code;
    int value;
    int cnt;
    int commit;
    int committed;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int m_value = 0, m_cnt = 0, m_committed = 0;
  int layout[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pos_of(input int code);
    int p = 0;
    for (int i = 0; i < 16; i++) if (layout[i] == code) p = i;
    return p;
  endfunction

  // Reference: what the entry should look like after an accepted key with this label
  task automatic model_key(input int code);
    exp_t e;
    e.commit = 0;
    if (code <= 9) begin
      if (m_cnt < 4) begin
        m_value = m_value * 10 + code;
        m_cnt++;
      end
    end else if (code == 15) begin
      m_value = m_value / 10;
      if (m_cnt > 0) m_cnt--;
    end else if (code == 12) begin
      m_value = 0;
      m_cnt   = 0;
    end else if (code == 14) begin
      m_committed = m_value;
      e.commit    = 1;
    end
    e.code      = code;
    e.value     = m_value;
    e.cnt       = m_cnt;
    e.committed = m_committed;
    q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge sysclk);
    #2;
  endtask

  task automatic tap(input int code, input int hold_scans, input int rel_scans);
    model_key(code);
    pressed = '0;
    pressed[pos_of(code)] = 1'b1;
    wait_cycles(hold_scans * SCAN);
    pressed = '0;
    wait_cycles(rel_scans * SCAN);
  endtask

  // Monitor: every key_valid pops one expected event
  initial begin : monitor
    exp_t e;
    int prev_kv = 0;
    int prev_cm = 0;
    forever begin
      @(negedge sysclk);
      if (rst_n) begin
        if (bus.commit) check("commit_single_cycle", prev_cm, 0);
        if (bus.commit && !bus.key_valid) begin
          checks++;
          errors++;
          $display("FAIL commit_without_key: got commit=1 key_valid=0 expected key_valid=1");
        end
        if (bus.key_valid) begin
          check("key_valid_single_cycle", prev_kv, 0);
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_key_valid: got key_code=%0d expected no event (t=%0t)",
                     bus.key_code, $time);
          end else begin
            e = q.pop_front();
            check("key_code", int'(bus.key_code), e.code);
            check("value", int'(bus.value), e.value);
            check("digit_count", int'(bus.digit_count), e.cnt);
            check("commit", int'(bus.commit), e.commit);
            check("committed_value", int'(bus.committed_value), e.committed);
          end
        end
        prev_kv = int'(bus.key_valid);
        prev_cm = int'(bus.commit);
      end else begin
        prev_kv = 0;
        prev_cm = 0;
      end
    end
  end

  initial begin : stimulus
    logic [3:0] col_exp [5];
    int lat;
    bit seen;
    col_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Reset state
    #23;
    check("rst_col", int'(bus.col), 4'b1110);
    check("rst_value", int'(bus.value), 0);
    check("rst_digit_count", int'(bus.digit_count), 0);
    check("rst_key_valid", int'(bus.key_valid), 0);
    check("rst_key_code", int'(bus.key_code), 0);
    check("rst_committed", int'(bus.committed_value), 0);
    check("rst_commit", int'(bus.commit), 0);
    @(negedge sysclk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a scan
    repeat (10) @(posedge sysclk);
    #3 rst_n = 1'b0;
    #1 check("async_rst_col", int'(bus.col), 4'b1110);
    @(negedge sysclk);
    rst_n = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge sysclk);
      if (i % 4 == 2) check("col_step", int'(bus.col), int'(col_exp[i/4]));
    end
    wait_cycles(2 * SCAN);

    // Digit entry, overflow, backspace, enter
    tap(4, 4, 4);
    tap(2, 4, 4);
    tap(0, 4, 4);
    tap(7, 4, 4);
    check("value_4207", int'(bus.value), 4207);
    check("count_4", int'(bus.digit_count), 4);
    tap(9, 4, 4);
    check("value_overflow_held", int'(bus.value), 4207);
    tap(15, 4, 4);
    check("value_backspace", int'(bus.value), 420);
    check("count_backspace", int'(bus.digit_count), 3);
    tap(14, 4, 4);
    check("committed_420", int'(bus.committed_value), 420);
    check("value_after_enter", int'(bus.value), 420);

    // Clear
    tap(12, 4, 4);
    check("value_clear", int'(bus.value), 0);
    check("count_clear", int'(bus.digit_count), 0);
    check("committed_kept", int'(bus.committed_value), 420);

    // Bounce on key 5, then held for 20 scans: one event
    model_key(5);
    for (int i = 0; i < 11; i++) begin
      pressed[pos_of(5)] = ~pressed[pos_of(5)];
      wait_cycles(3);
    end
    pressed = '0;
    pressed[pos_of(5)] = 1'b1;
    wait_cycles(20 * SCAN);
    pressed = '0;
    wait_cycles(4 * SCAN);

    // Chord 1+3 gives nothing, lifting 3 gives nothing, then a clean 1
    pressed = '0;
    pressed[pos_of(1)] = 1'b1;
    pressed[pos_of(3)] = 1'b1;
    wait_cycles(4 * SCAN);
    pressed[pos_of(3)] = 1'b0;
    wait_cycles(4 * SCAN);
    pressed = '0;
    wait_cycles(4 * SCAN);
    tap(1, 4, 4);
    check("value_51", int'(bus.value), 51);

    // Randomized presses, with occasional chords that must stay silent
    for (int n = 0; n < 30; n++) begin
      int a, b;
      wait_cycles($urandom_range(0, SCAN - 1));
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        pressed = '0;
        pressed[a] = 1'b1;
        pressed[b] = 1'b1;
        wait_cycles($urandom_range(4, 6) * SCAN);
        pressed = '0;
        wait_cycles(4 * SCAN);
      end else begin
        tap(layout[$urandom_range(0, 15)], $urandom_range(4, 6), $urandom_range(4, 5));
      end
    end
    check("rand_value", int'(bus.value), m_value);
    check("rand_count", int'(bus.digit_count), m_cnt);
    check("rand_committed", int'(bus.committed_value), m_committed);

    // Reset while a key is held: state wiped, full debounce required afterwards
    model_key(8);
    pressed = '0;
    pressed[pos_of(8)] = 1'b1;
    wait_cycles(5 * SCAN);
    #3 rst_n = 1'b0;
    #1;
    check("held_rst_committed", int'(bus.committed_value), 0);
    check("held_rst_value", int'(bus.value), 0);
    check("held_rst_col", int'(bus.col), 4'b1110);
    q.delete();
    m_value = 0;
    m_cnt = 0;
    m_committed = 0;
    wait_cycles(20);
    model_key(8);
    @(negedge sysclk);
    rst_n = 1'b1;
    lat = 0;
    seen = 1'b0;
    for (int i = 1; i <= 100 && !seen; i++) begin
      @(negedge sysclk);
      if (bus.key_valid) begin
        seen = 1'b1;
        lat = i;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL post_reset_key_timeout: got no key_valid in 100 cycles expected one");
    end else begin
      checks++;
      if (lat < 44 || lat > 54) begin
        errors++;
        $display("FAIL post_reset_latency: got %0d cycles expected 44..54", lat);
      end
    end
    pressed = '0;
    wait_cycles(5 * SCAN);
    check("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_decimal_entry.md
Name: keypad_decimal_entry

Overview:
- Scans a 4x4 matrix keypad on a Pmod header, debounces it and turns key presses into a 4-digit decimal entry value (0..9999).
- It is the input counterpart of the multiplexed 4-digit 7-segment display driver: that driver scans digits out, this block scans key columns in.
- The live entry value is sized to feed the display driver directly.
- An Enter key commits the entry to a separate register for downstream logic.

Parameters:
- SCAN_DIV, 10000: sysclk cycles each column is driven (dwell). Must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required before the debounced key map updates. Must be >= 1.

Ports:
- sysclk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- col  out  4  column drive, active-low, exactly one bit low at a time
- row  in  4  row sense, active-low (pulled up), asynchronous to sysclk
- value  out  15  live entry value, 0..9999
- digit_count  out  3  digits entered, 0..4
- key_valid  out  1  one-cycle pulse on an accepted key press
- key_code  out  4  code of last accepted key; valid with key_valid, held otherwise
- committed_value  out  15  value latched by Enter
- commit  out  1  one-cycle pulse when committed_value is loaded

Behaviour:
- Reset (async, rst_n=0): col=4'b1110; value=0; digit_count=0; key_valid=0; key_code=0; committed_value=0; commit=0. Dwell counter, column index, raw/prev/debounced maps and match counter all cleared. FSM goes to IDLE.
- Reset mid-scan or mid-press discards all in-progress state. A key still held after reset release goes through the full debounce again.
- row passes through a 2-flop synchronizer before any use.
- Column scan:
  - col_idx 0..3; col = ~(1<<col_idx).
  - On the last cycle of each dwell (dwell counter = SCAN_DIV-1), the synced row is sampled into the raw map: bit r*4+col_idx = ~row_sync[r].
  - col_idx then advances and wraps 3->0.
  - One full scan = 4*SCAN_DIV cycles.
- Debounce, evaluated on the col 3 sample edge (end of scan):
  - If raw == prev_raw, match_cnt increments, saturating at DEBOUNCE_SCANS; otherwise match_cnt = 0.
  - prev_raw <= raw.
  - If raw == prev_raw and match_cnt+1 >= DEBOUNCE_SCANS, debounced <= raw.
  - A key held continuously from the start of scan N is therefore debounced at the end of scan N+DEBOUNCE_SCANS.
- Key map, index r*4+c:
  - row 0: 1, 2, 3, A
  - row 1: 4, 5, 6, B
  - row 2: 7, 8, 9, C
  - row 3: 0, F, E, D
  - key_code equals the hex value of the label.
- FSM, evaluated on the debounced map every cycle:
  - IDLE, debounced has exactly one bit set: next edge key_valid=1, key_code=code, action applied on that same edge; go HELD.
  - IDLE, debounced has more than one bit set: no event; go HELD.
  - HELD, debounced all zero: go IDLE. Otherwise stay in HELD. No events in HELD: no auto-repeat, and extra keys added while holding are ignored.
- Actions, registered on the key_valid edge:
  - Digit 0-9: if digit_count < 4, value = value*10 + d and digit_count++. If digit_count = 4, ignored (key_valid still pulses). Compute in 18 bits and truncate to 15; the count guard keeps value <= 9999. Leading zeros count as digits.
  - F (backspace): value = value/10; digit_count = digit_count-1 if > 0.
  - C (clear): value = 0; digit_count = 0.
  - E (enter): committed_value = value; commit=1 for one cycle. Entry is unchanged.
  - A, B, D: key_valid/key_code only; no other effect.
- key_valid and commit are never high for more than one consecutive cycle. At most one event per press.

Test Plan (bench uses SCAN_DIV=4, DEBOUNCE_SCANS=2, so one scan = 16 cycles):
- Reset: hold rst_n=0 mid-scan -> col=1110 and all outputs 0 asynchronously. After release, col steps 1110,1101,1011,0111 every 4 cycles and wraps.
- Press 4,2,0,7 one key at a time, each held 4 scans with 4 released scans between -> exactly one key_valid per key. key_code=4,2,0,7. Final value=4207, digit_count=4.
- Fifth digit 9 -> key_valid with key_code=9; value stays 4207. Then F -> value=420, digit_count=3. Then E -> commit pulse, committed_value=420, value=420.
- Bounce: key 5 toggled every 3 cycles for 2 scans, then held steady -> no key_valid during toggling, exactly one key_valid for 5 after stable. Held 20 scans -> still only one pulse.
- Two keys 1 and 3 pressed together -> no key_valid. Releasing 3 while 1 is held -> still none. Full release, then press 1 -> key_valid with key_code=1.
- C with value=420 -> value=0, digit_count=0, committed_value stays 420. Assert rst_n=0 while a key is held -> committed_value=0, and no key_valid until after reset release plus the full debounce.
